// File: rtl/alu_ctrl_pkg.sv
//------------------------------------------------------------------------------
// Module   : alu_ctrl_pkg
// Brief    : Opcode, state encodings and control decode for alu_arbiter.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package alu_ctrl_pkg;

   typedef logic [1:0] op_t;
   typedef logic [1:0] state_t;

   localparam op_t OP_ADD = 2'b00;
   localparam op_t OP_INC = 2'b01;
   localparam op_t OP_NEG = 2'b10;
   localparam op_t OP_SUB = 2'b11;

   localparam state_t IDLE = 2'd0;
   localparam state_t EXEC = 2'd1;
   localparam state_t RESP = 2'd2;

   // One-hot control vector ordered {sub, neg, inc, add}, so the opcode is the bit index.
   function automatic logic [3:0] op_to_ctrl(input op_t op);
      logic [3:0] c_ctrl;
      c_ctrl = 4'b0000;
      case (op)
         OP_ADD:  c_ctrl = 4'b0001;
         OP_INC:  c_ctrl = 4'b0010;
         OP_NEG:  c_ctrl = 4'b0100;
         OP_SUB:  c_ctrl = 4'b1000;
         default: c_ctrl = 4'b0000;
      endcase
      return c_ctrl;
   endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arb2.sv
//------------------------------------------------------------------------------
// Module   : rr_arb2
// Brief    : Combinational two-way round-robin grant; history is held by caller.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rr_arb2 (
   input  logic valid0,
   input  logic valid1,
   input  logic last_grant,
   output logic gnt0,
   output logic gnt1,
   output logic gnt_id
);

   logic w_gnt0;
   logic w_gnt1;

   // On a tie the requester that did not win last time takes the grant.
   assign w_gnt0 = valid0 & (~valid1 | last_grant);
   assign w_gnt1 = valid1 & (~valid0 | ~last_grant);

   assign gnt0   = w_gnt0;
   assign gnt1   = w_gnt1;
   assign gnt_id = w_gnt1;

endmodule

`default_nettype wire

// File: rtl/alu_arbiter.sv
//------------------------------------------------------------------------------
// Module   : alu_arbiter
// Brief    : Shares one combinational ALU between two requesters, round-robin.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module alu_arbiter
   import alu_ctrl_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [1:0]       req0_op,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [1:0]       req1_op,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [WIDTH-1:0] rsp_data,
   output logic             rsp_z,
   output logic             rsp_n,
   output logic             busy,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic             alu_add,
   output logic             alu_inc,
   output logic             alu_neg,
   output logic             alu_sub,
   input  logic [WIDTH-1:0] alu_out,
   input  logic             alu_z,
   input  logic             alu_n
);

   state_t           r_state;
   logic             r_last_grant;
   logic             r_owner;
   op_t              r_op;
   logic [WIDTH-1:0] r_alu_a;
   logic [WIDTH-1:0] r_alu_b;
   logic             r_rsp_valid;
   logic             r_rsp_id;
   logic [WIDTH-1:0] r_rsp_data;
   logic             r_rsp_z;
   logic             r_rsp_n;

   logic             w_idle;
   logic             w_gnt0;
   logic             w_gnt1;
   logic             w_gnt_id;
   logic             w_accept;
   logic [3:0]       w_ctrl;

   rr_arb2 u_rr_arb2 (
      .valid0     (req0_valid),
      .valid1     (req1_valid),
      .last_grant (r_last_grant),
      .gnt0       (w_gnt0),
      .gnt1       (w_gnt1),
      .gnt_id     (w_gnt_id)
   );

   assign w_idle   = (r_state == IDLE);
   assign w_accept = w_idle & (w_gnt0 | w_gnt1);

   // Controls decode from state so an async reset clears them at once.
   assign w_ctrl   = (r_state == EXEC) ? op_to_ctrl(r_op) : 4'b0000;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_last_grant <= 1'b1;
         r_owner      <= 1'b0;
         r_op         <= OP_ADD;
         r_alu_a      <= '0;
         r_alu_b      <= '0;
         r_rsp_valid  <= 1'b0;
         r_rsp_id     <= 1'b0;
         r_rsp_data   <= '0;
         r_rsp_z      <= 1'b0;
         r_rsp_n      <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_op         <= w_gnt_id ? req1_op : req0_op;
                  r_alu_a      <= w_gnt_id ? req1_a  : req0_a;
                  r_alu_b      <= w_gnt_id ? req1_b  : req0_b;
                  r_owner      <= w_gnt_id;
                  r_last_grant <= w_gnt_id;
                  r_state      <= EXEC;
               end
            end
            EXEC: begin
               r_rsp_data  <= alu_out;
               r_rsp_z     <= alu_z;
               r_rsp_n     <= alu_n;
               r_rsp_id    <= r_owner;
               r_rsp_valid <= 1'b1;
               r_state     <= RESP;
            end
            RESP: begin
               if (rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_state     <= IDLE;
               end
            end
            default: begin
               r_rsp_valid <= 1'b0;
               r_state     <= IDLE;
            end
         endcase
      end
   end

   assign req0_ready = w_idle & w_gnt0;
   assign req1_ready = w_idle & w_gnt1;

   assign rsp_valid  = r_rsp_valid;
   assign rsp_id     = r_rsp_id;
   assign rsp_data   = r_rsp_data;
   assign rsp_z      = r_rsp_z;
   assign rsp_n      = r_rsp_n;
   assign busy       = ~w_idle;

   assign alu_a      = r_alu_a;
   assign alu_b      = r_alu_b;
   assign alu_add    = w_ctrl[0];
   assign alu_inc    = w_ctrl[1];
   assign alu_neg    = w_ctrl[2];
   assign alu_sub    = w_ctrl[3];

endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
//------------------------------------------------------------------------------
// Module   : tb_alu_arbiter
// Brief    : Directed self-checking bench for alu_arbiter with an ALU model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_alu_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req0_valid, req0_ready;
   logic [1:0]  req0_op;
   logic [31:0] req0_a, req0_b;
   logic        req1_valid, req1_ready;
   logic [1:0]  req1_op;
   logic [31:0] req1_a, req1_b;
   logic        rsp_valid, rsp_ready, rsp_id, rsp_z, rsp_n, busy;
   logic [31:0] rsp_data, alu_a, alu_b, alu_out;
   logic        alu_add, alu_inc, alu_neg, alu_sub, alu_z, alu_n;
   logic [3:0]  ctrl;

   int          checks = 0;
   int          failures = 0;
   logic        exp_id;
   logic [31:0] exp_data;
   logic [1:0]  exp_op;

   always #5 clk = ~clk;

   alu_arbiter #(.WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
      .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
      .req1_a(req1_a), .req1_b(req1_b),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_data(rsp_data), .rsp_z(rsp_z), .rsp_n(rsp_n), .busy(busy),
      .alu_a(alu_a), .alu_b(alu_b),
      .alu_add(alu_add), .alu_inc(alu_inc), .alu_neg(alu_neg), .alu_sub(alu_sub),
      .alu_out(alu_out), .alu_z(alu_z), .alu_n(alu_n)
   );

   // External ALU: the control lines select the arithmetic.
   always_comb begin
      alu_out = 32'h0;
      if (alu_add)      alu_out = alu_a + alu_b;
      else if (alu_inc) alu_out = alu_a + 32'd1;
      else if (alu_neg) alu_out = 32'd0 - alu_a;
      else if (alu_sub) alu_out = alu_b - alu_a;
   end
   assign alu_z = (alu_out == 32'h0);
   assign alu_n = alu_out[31];
   assign ctrl  = {alu_sub, alu_neg, alu_inc, alu_add};

   function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      case (op)
         2'b00:   return a + b;
         2'b01:   return a + 32'd1;
         2'b10:   return 32'd0 - a;
         default: return b - a;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Entered at a falling edge in IDLE with rsp_ready high; returns likewise.
   task automatic single_op(input logic id, input logic [1:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] data,
                            input logic z, input logic n);
      if (id) begin
         req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
      end else begin
         req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
      end
      #1;
      chk("idle_ready0", {31'd0, req0_ready}, {31'd0, ~id});
      chk("idle_ready1", {31'd0, req1_ready}, {31'd0, id});
      chk("idle_busy", {31'd0, busy}, 32'd0);
      @(posedge clk); @(negedge clk);
      req0_valid = 1'b0; req1_valid = 1'b0;
      chk("exec_ctrl", {28'd0, ctrl}, {28'd0, 4'b0001 << op});
      chk("exec_alu_a", alu_a, a);
      chk("exec_alu_b", alu_b, b);
      chk("exec_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("exec_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
      @(negedge clk);
      chk("resp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("resp_id", {31'd0, rsp_id}, {31'd0, id});
      chk("resp_data", rsp_data, data);
      chk("resp_z", {31'd0, rsp_z}, {31'd0, z});
      chk("resp_n", {31'd0, rsp_n}, {31'd0, n});
      chk("resp_ctrl", {28'd0, ctrl}, 32'd0);
      @(negedge clk);
      chk("back_idle_valid", {31'd0, rsp_valid}, 32'd0);
      chk("back_idle_busy", {31'd0, busy}, 32'd0);
   endtask

   initial begin
      rst_n = 1'b0; rsp_ready = 1'b1;
      req0_valid = 1'b0; req0_op = 2'b00; req0_a = 32'd0; req0_b = 32'd0;
      req1_valid = 1'b0; req1_op = 2'b00; req1_a = 32'd0; req1_b = 32'd0;
      @(negedge clk); @(negedge clk);
      chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rst_rsp_data", rsp_data, 32'd0);
      chk("rst_rsp_flags", {29'd0, rsp_id, rsp_z, rsp_n}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_alu_ops", alu_a | alu_b, 32'd0);
      chk("rst_ctrl", {28'd0, ctrl}, 32'd0);
      chk("rst_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
      rst_n = 1'b1;

      // Directed single operations, ending with last grant = 1.
      single_op(1'b0, 2'b00, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0);
      single_op(1'b0, 2'b10, 32'd1, 32'd0, 32'hFFFF_FFFF, 1'b0, 1'b1);
      single_op(1'b0, 2'b01, 32'hFFFF_FFFF, 32'd0, 32'd0, 1'b1, 1'b0);
      single_op(1'b1, 2'b11, 32'd3, 32'd3, 32'd0, 1'b1, 1'b0);

      // Both requesters continuously valid: grants alternate 0,1,0,1.
      req0_op = 2'b00; req0_a = 32'd1; req0_b = 32'd1;
      req1_op = 2'b11; req1_a = 32'd1; req1_b = 32'd10;
      req0_valid = 1'b1; req1_valid = 1'b1;
      for (int k = 0; k < 8; k++) begin
         exp_id   = k[0];
         exp_op   = exp_id ? req1_op : req0_op;
         exp_data = exp_id ? model(req1_op, req1_a, req1_b) : model(req0_op, req0_a, req0_b);
         #1;
         chk("rr_ready0", {31'd0, req0_ready}, {31'd0, ~exp_id});
         chk("rr_ready1", {31'd0, req1_ready}, {31'd0, exp_id});
         chk("rr_busy_idle", {31'd0, busy}, 32'd0);
         @(posedge clk); @(negedge clk);
         if (exp_id) req1_b = req1_b + 32'd10;
         else        req0_a = req0_a + 32'd1;
         chk("rr_exec_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
         chk("rr_exec_busy", {31'd0, busy}, 32'd1);
         chk("rr_exec_ctrl", {28'd0, ctrl}, {28'd0, 4'b0001 << exp_op});
         @(negedge clk);
         chk("rr_resp_id", {31'd0, rsp_id}, {31'd0, exp_id});
         chk("rr_resp_data", rsp_data, exp_data);
         chk("rr_resp_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
         chk("rr_resp_busy", {31'd0, busy}, 32'd1);
         @(negedge clk);
      end

      // Response back-pressure with both requesters waiting.
      rsp_ready = 1'b0;
      req0_op = 2'b00; req0_a = 32'd2; req0_b = 32'd3;
      req1_op = 2'b01; req1_a = 32'd9; req1_b = 32'd0;
      #1;
      chk("bp_grant0", {30'd0, req1_ready, req0_ready}, 32'd1);
      @(posedge clk); @(negedge clk);
      @(negedge clk);
      for (int k = 0; k < 5; k++) begin
         chk("bp_valid", {31'd0, rsp_valid}, 32'd1);
         chk("bp_data", rsp_data, 32'd5);
         chk("bp_flags", {29'd0, rsp_id, rsp_z, rsp_n}, 32'd0);
         chk("bp_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
         @(negedge clk);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      #1;
      chk("bp_next_grant1", {30'd0, req1_ready, req0_ready}, 32'd2);
      @(posedge clk); @(negedge clk);
      req0_valid = 1'b0; req1_valid = 1'b0;
      chk("bp_exec_inc", {28'd0, ctrl}, 32'd2);
      @(negedge clk);
      chk("bp_inc_data", rsp_data, 32'd10);
      chk("bp_inc_id", {31'd0, rsp_id}, 32'd1);
      @(negedge clk);

      // Async reset in the middle of EXEC drops the operation.
      req0_valid = 1'b1; req0_op = 2'b00; req0_a = 32'd100; req0_b = 32'd23;
      @(posedge clk); @(negedge clk);
      req0_valid = 1'b0;
      chk("rst_mid_exec_add", {31'd0, alu_add}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("async_ctrl", {28'd0, ctrl}, 32'd0);
      chk("async_busy", {31'd0, busy}, 32'd0);
      chk("async_alu_a", alu_a, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("drop_no_rsp1", {31'd0, rsp_valid}, 32'd0);
      @(negedge clk);
      chk("drop_no_rsp2", {31'd0, rsp_valid}, 32'd0);
      req0_valid = 1'b1; req0_op = 2'b00; req0_a = 32'd4; req0_b = 32'd4;
      req1_valid = 1'b1; req1_op = 2'b01; req1_a = 32'd0;
      #1;
      chk("post_rst_tie", {30'd0, req1_ready, req0_ready}, 32'd1);
      @(posedge clk); @(negedge clk);
      req0_valid = 1'b0; req1_valid = 1'b0;
      @(negedge clk);
      chk("post_rst_data", rsp_data, 32'd8);
      chk("post_rst_id", {31'd0, rsp_id}, 32'd0);
      @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
